// File: rtl/uart_frame_decoder.sv
// Frame decoder for a UART byte stream: SOF, LEN, LEN payload bytes, buffered and then drained.
// Define FRAME_CHECKSUM_EN to expect a trailing XOR checksum byte (CHECK state and XOR logic).
module uart_frame_decoder #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    MAX_LEN       = 16,
   parameter int                    TIMEOUT_TICKS = 320,
   parameter logic [DATA_WIDTH-1:0] SOF           = DATA_WIDTH'(8'hA5)
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [DATA_WIDTH-1:0] byte_in,
   input  logic                  byte_valid,
   input  logic                  baudTick,
   output logic [DATA_WIDTH-1:0] payload_out,
   output logic                  payload_valid,
   input  logic                  payload_ready,
   output logic                  frame_done,
   output logic                  frame_error,
   output logic                  busy,
   output logic [2:0]            dbg_state
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
   localparam logic [DATA_WIDTH-1:0] ONE_B     = DATA_WIDTH'(1);
   localparam logic [IW-1:0]         ONE_I     = IW'(1);
   localparam logic [TW-1:0]         ONE_T     = TW'(1);
   localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
`ifdef FRAME_CHECKSUM_EN
      S_CHECK   = 3'd3,
`endif
      S_DRAIN   = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           wr_q, wr_d;
   logic [IW-1:0]           rd_q, rd_d;
   logic [DATA_WIDTH-1:0]   len_q, len_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   buf_q [MAX_LEN];
   logic                    buf_we;
   logic                    rx_state;
   logic                    tmo_expire;
   logic                    last_wr;
   logic                    last_rd;
   logic                    done_c;
   logic                    ovr_c;
`ifdef FRAME_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   chk_q, chk_d;
`endif

`ifdef FRAME_CHECKSUM_EN
   assign rx_state = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
`else
   assign rx_state = (state_q == S_LEN) || (state_q == S_PAYLOAD);
`endif

   assign last_wr    = (DATA_WIDTH'(wr_q) == (len_q - ONE_B));
   assign last_rd    = (DATA_WIDTH'(rd_q) == (len_q - ONE_B));
   assign tmo_expire = rx_state && baudTick && !byte_valid && (tmo_q == TMO_LAST);

   // payload_valid/payload_ready: a byte transfers on every cycle both are high;
   // payload_out stays on buffer[rd_idx] while valid is high and ready is low.
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      rd_d          = rd_q;
      len_d         = len_q;
      tmo_d         = tmo_q;
      err_d         = 1'b0;
      buf_we        = 1'b0;
      done_c        = 1'b0;
      ovr_c         = 1'b0;
      payload_valid = 1'b0;
      payload_out   = '0;
`ifdef FRAME_CHECKSUM_EN
      chk_d         = chk_q;
`endif

      if (byte_valid || !rx_state) begin
         tmo_d = '0;
      end else if (baudTick) begin
         tmo_d = tmo_q + ONE_T;
      end

      case (state_q)
         S_IDLE: begin
            len_d = '0;
`ifdef FRAME_CHECKSUM_EN
            chk_d = '0;
`endif
            if (byte_valid && (byte_in == SOF)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (byte_valid) begin
               if (byte_in > MAX_LEN_B) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (byte_in == '0) begin
`ifdef FRAME_CHECKSUM_EN
                  len_d   = '0;
                  chk_d   = byte_in;
                  state_d = S_CHECK;
`else
                  done_c  = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  len_d   = byte_in;
`ifdef FRAME_CHECKSUM_EN
                  chk_d   = byte_in;
`endif
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (byte_valid) begin
               buf_we = 1'b1;
               wr_d   = wr_q + ONE_I;
`ifdef FRAME_CHECKSUM_EN
               chk_d  = chk_q ^ byte_in;
               if (last_wr) state_d = S_CHECK;
`else
               if (last_wr) state_d = S_DRAIN;
`endif
            end
         end
`ifdef FRAME_CHECKSUM_EN
         S_CHECK: begin
            if (byte_valid) begin
               if (byte_in != chk_q) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else if (len_q == '0) begin
                  done_c  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
`endif
         S_DRAIN: begin
            payload_valid = 1'b1;
            payload_out   = buf_q[rd_q];
            if (payload_ready) begin
               rd_d = rd_q + ONE_I;
               if (last_rd) begin
                  done_c  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            // A dropped SOF means the sender has started a new frame too early.
            // If it lands on the completing handshake, the error waits one cycle
            // so frame_done and frame_error never share a cycle.
            if (byte_valid && (byte_in == SOF)) begin
               if (payload_ready && last_rd) err_d = 1'b1;
               else                          ovr_c = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (tmo_expire) begin
         err_d   = 1'b1;
         state_d = S_IDLE;
      end

      if (state_d == S_IDLE) begin
         wr_d = '0;
         rd_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         len_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) chk_q <= '0;
      else       chk_q <= chk_d;
   end
`endif

   // Buffer has no reset: aborted frames only rewind the indices.
   always_ff @(posedge clk) begin
      if (buf_we) buf_q[wr_q] <= byte_in;
   end

   assign frame_done  = done_c;
   assign frame_error = err_q | ovr_c;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: cycle vector table plus hand sequences for timeout and reset.
`timescale 1ns/1ps
module tb_uart_frame_decoder;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [7:0] byte_in = '0;
   logic       byte_valid = 1'b0;
   logic       baudTick = 1'b0;
   logic       payload_ready = 1'b0;
   logic [7:0] payload_out;
   logic       payload_valid;
   logic       frame_done;
   logic       frame_error;
   logic       busy;
   logic [2:0] dbg_state;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic       bv;
      logic [7:0] b;
      logic       rdy;
      logic       pv;
      logic [7:0] po;
      logic       done;
      logic       err;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   uart_frame_decoder dut (
      .clk           (clk),
      .rstN          (rstN),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .baudTick      (baudTick),
      .payload_out   (payload_out),
      .payload_valid (payload_valid),
      .payload_ready (payload_ready),
      .frame_done    (frame_done),
      .frame_error   (frame_error),
      .busy          (busy),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end expected end before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // one call = one clock cycle; outputs are settled when it returns
   task automatic step(input logic bv, input logic [7:0] b, input logic tick, input logic rdy);
      @(posedge clk);
      #1;
      byte_valid    = bv;
      byte_in       = b;
      baudTick      = tick;
      payload_ready = rdy;
      #1;
   endtask

   task automatic add(input logic bv, input logic [7:0] b, input logic rdy, input logic pv,
                      input logic [7:0] po, input logic done, input logic err, input logic bsy);
      vec_t v;
      v.bv = bv; v.b = b; v.rdy = rdy; v.pv = pv; v.po = po;
      v.done = done; v.err = err; v.busy = bsy;
      vecs.push_back(v);
      if (pv && rdy) exp_q.push_back(po);
   endtask

   // scoreboard: every accepted payload byte must be the next expected one
   always @(negedge clk) begin
      if (rstN && payload_valid && payload_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got %0h expected none", payload_out);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (payload_out !== e) begin
               bad++;
               $display("FAIL sb_data: got %0h expected %0h", payload_out, e);
            end
         end
      end
   end

   logic [7:0] pb [16];
`ifdef FRAME_CHECKSUM_EN
   logic [7:0] ck;
`endif

   initial begin
      // ---------------- vector table ----------------
      // non-SOF byte in IDLE is ignored
      add(1, 8'h33, 1, 0, 8'h00, 0, 0, 0);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
      // good 3-byte frame
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
      add(1, 8'h03, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h11, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h22, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h33, 1, 0, 8'h00, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      add(1, 8'h03, 1, 0, 8'h00, 0, 0, 1);
`endif
      add(0, 8'h00, 1, 1, 8'h11, 0, 0, 1);
      add(0, 8'h00, 1, 1, 8'h22, 0, 0, 1);
      add(0, 8'h00, 1, 1, 8'h33, 1, 0, 1);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
      // 2-byte frame: bad checksum when enabled, plain delivery otherwise
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
      add(1, 8'h02, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h10, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h20, 1, 0, 8'h00, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      add(1, 8'hFF, 1, 0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
`else
      add(0, 8'h00, 1, 1, 8'h10, 0, 0, 1);
      add(0, 8'h00, 1, 1, 8'h20, 1, 0, 1);
      add(1, 8'hFF, 1, 0, 8'h00, 0, 0, 0);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
`endif
      // LEN 17 > MAX_LEN aborts; SOF in the error cycle starts the next frame
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
      add(1, 8'h11, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'hA5, 1, 0, 8'h00, 0, 1, 0);
      add(1, 8'h01, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'h5A, 1, 0, 8'h00, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      add(1, 8'h5B, 1, 0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 1, 1, 8'h5A, 1, 0, 1);
`else
      add(1, 8'h5B, 1, 1, 8'h5A, 1, 0, 1);
`endif
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
      // LEN 0
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
`ifdef FRAME_CHECKSUM_EN
      add(1, 8'h00, 1, 0, 8'h00, 0, 0, 1);
`endif
      add(1, 8'h00, 1, 0, 8'h00, 1, 0, 1);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
      // LEN == MAX_LEN
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
      add(1, 8'h10, 1, 0, 8'h00, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      ck = 8'h10;
`endif
      for (int i = 0; i < 16; i++) begin
         pb[i] = 8'(i * 7 + 3);
`ifdef FRAME_CHECKSUM_EN
         ck = ck ^ pb[i];
`endif
         add(1, pb[i], 1, 0, 8'h00, 0, 0, 1);
      end
`ifdef FRAME_CHECKSUM_EN
      add(1, ck, 1, 0, 8'h00, 0, 0, 1);
`endif
      for (int i = 0; i < 16; i++) add(0, 8'h00, 1, 1, pb[i], (i == 15), 0, 1);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
      // stall in DRAIN with SOF overrun, then overrun on the final handshake
      add(1, 8'hA5, 1, 0, 8'h00, 0, 0, 0);
      add(1, 8'h02, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'hC1, 1, 0, 8'h00, 0, 0, 1);
      add(1, 8'hC2, 1, 0, 8'h00, 0, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      add(1, 8'h01, 1, 0, 8'h00, 0, 0, 1);
`endif
      for (int i = 0; i < 10; i++) begin
         add((i == 4) || (i == 6), (i == 4) ? 8'hA5 : ((i == 6) ? 8'h77 : 8'h00), 0,
             1, 8'hC1, 0, (i == 4), 1);
      end
      add(0, 8'h00, 1, 1, 8'hC1, 0, 0, 1);
      add(1, 8'hA5, 1, 1, 8'hC2, 1, 0, 1);
      add(0, 8'h00, 1, 0, 8'h00, 0, 1, 0);
      add(0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pv", payload_valid, 1'b0);
      chk("rst_po", payload_out, 8'h00);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_err", frame_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_state", dbg_state, 3'd0);
      @(negedge clk) rstN = 1'b1;

      // ---------------- apply table ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].bv, vecs[i].b, 1'b0, vecs[i].rdy);
         chk($sformatf("v%0d_pv", i), payload_valid, vecs[i].pv);
         chk($sformatf("v%0d_po", i), payload_out, vecs[i].po);
         chk($sformatf("v%0d_done", i), frame_done, vecs[i].done);
         chk($sformatf("v%0d_err", i), frame_error, vecs[i].err);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      end

      // ---------------- timeout expires on the 320th tick ----------------
      step(1, 8'hA5, 0, 1);
      step(1, 8'h04, 0, 1);
      step(1, 8'h01, 0, 1);
      for (int t = 0; t < 319; t++) begin
         step(0, 8'h00, 1, 1);
         step(0, 8'h00, 0, 1);
      end
      chk("tmo319_busy", busy, 1'b1);
      chk("tmo319_err", frame_error, 1'b0);
      chk("tmo319_state", dbg_state, 3'd2);
      step(0, 8'h00, 1, 1);
      chk("tmo320_err_now", frame_error, 1'b0);
      step(0, 8'h00, 0, 1);
      chk("tmo_err", frame_error, 1'b1);
      chk("tmo_idle", busy, 1'b0);
      chk("tmo_no_done", frame_done, 1'b0);
      step(0, 8'h00, 0, 1);
      chk("tmo_err_pulse", frame_error, 1'b0);

      // ---------------- byte on the expiring tick wins ----------------
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      step(1, 8'hA5, 0, 1);
      step(1, 8'h04, 0, 1);
      step(1, 8'h01, 0, 1);
      for (int t = 0; t < 319; t++) begin
         step(0, 8'h00, 1, 1);
         step(0, 8'h00, 0, 1);
      end
      step(1, 8'h02, 1, 1);
      chk("race_err_now", frame_error, 1'b0);
      for (int t = 0; t < 5; t++) begin
         step(0, 8'h00, 1, 1);
         step(0, 8'h00, 0, 1);
      end
      chk("race_err", frame_error, 1'b0);
      chk("race_busy", busy, 1'b1);
      step(1, 8'h03, 0, 1);
      step(1, 8'h04, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      step(1, 8'h00, 0, 1);
`endif
      for (int k = 0; k < 4; k++) begin
         step(0, 8'h00, 0, 1);
         chk($sformatf("race_po%0d", k), payload_out, 8'(k + 1));
         chk($sformatf("race_done%0d", k), frame_done, (k == 3));
      end
      step(0, 8'h00, 0, 1);
      chk("race_idle", busy, 1'b0);

      // ---------------- reset in PAYLOAD ----------------
      step(1, 8'hA5, 0, 1);
      step(1, 8'h03, 0, 1);
      step(1, 8'hAA, 0, 1);
      step(0, 8'h00, 0, 1);
      chk("rp_pre_busy", busy, 1'b1);
      #1 rstN = 1'b0;
      #1;
      chk("rp_busy", busy, 1'b0);
      chk("rp_pv", payload_valid, 1'b0);
      chk("rp_po", payload_out, 8'h00);
      chk("rp_err", frame_error, 1'b0);
      chk("rp_done", frame_done, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstN = 1'b1;
      step(0, 8'h00, 0, 1);
      chk("rp_after_err", frame_error, 1'b0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      step(1, 8'hA5, 0, 1);
      step(1, 8'h03, 0, 1);
      step(1, 8'h11, 0, 1);
      step(1, 8'h22, 0, 1);
      step(1, 8'h33, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      step(1, 8'h03, 0, 1);
`endif
      step(0, 8'h00, 0, 1);
      chk("rp_f_po0", payload_out, 8'h11);
      step(0, 8'h00, 0, 1);
      chk("rp_f_po1", payload_out, 8'h22);
      step(0, 8'h00, 0, 1);
      chk("rp_f_po2", payload_out, 8'h33);
      chk("rp_f_done", frame_done, 1'b1);
      chk("rp_f_err", frame_error, 1'b0);

      // ---------------- reset in DRAIN ----------------
      step(1, 8'hA5, 0, 1);
      step(1, 8'h01, 0, 1);
      step(1, 8'hE7, 0, 1);
`ifdef FRAME_CHECKSUM_EN
      step(1, 8'hE6, 0, 1);
`endif
      step(0, 8'h00, 0, 0);
      chk("rd_pre_pv", payload_valid, 1'b1);
      chk("rd_pre_po", payload_out, 8'hE7);
      #1 rstN = 1'b0;
      #1;
      chk("rd_pv", payload_valid, 1'b0);
      chk("rd_po", payload_out, 8'h00);
      chk("rd_busy", busy, 1'b0);
      chk("rd_err", frame_error, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstN = 1'b1;
      step(0, 8'h00, 0, 1);
      chk("rd_after_err", frame_error, 1'b0);
      chk("rd_after_pv", payload_valid, 1'b0);

      step(0, 8'h00, 0, 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of received bytes.
REQ-002 SHALL have parameter MAX_LEN, default 16: payload buffer depth in bytes, range 1..255.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 320: number of baudTick pulses without a byte that aborts a frame.
REQ-004 SHALL have parameter SOF, default 8'hA5: start-of-frame byte value.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rstN  input  1  reset, asynchronous assert, active-low.
REQ-007 byte_in  input  DATA_WIDTH  received byte, qualified by byte_valid.
REQ-008 byte_valid  input  1  one-cycle strobe per received byte, driven by the UART receiver's byte-received pulse.
REQ-009 baudTick  input  1  16x oversample tick, used only for the timeout.
REQ-010 payload_out  output  DATA_WIDTH  current payload byte.
REQ-011 payload_valid  output  1  payload_out valid.
REQ-012 payload_ready  input  1  downstream accepts payload_out.
REQ-013 frame_done  output  1  one-cycle pulse: frame fully delivered.
REQ-014 frame_error  output  1  one-cycle pulse: frame discarded.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Frame format SHALL be: SOF, LEN, LEN payload bytes, then CHK when FRAME_CHECKSUM_EN is defined.
REQ-017 States SHALL be IDLE, LEN, PAYLOAD, CHECK, DRAIN.
REQ-018 IDLE: byte_valid with byte_in==SOF -> LEN; any other byte is ignored, with no error.
REQ-019 LEN: on byte_valid, LEN>MAX_LEN -> frame_error, IDLE; LEN==0 -> CHECK (or directly frame_done and IDLE when checksum is disabled); else store LEN and go to PAYLOAD.
REQ-020 PAYLOAD: each byte_valid writes byte_in to buffer[wr_idx], increments wr_idx, and XORs the byte into the running checksum; after the LEN-th byte -> CHECK (or DRAIN when checksum is disabled).
REQ-021 Running checksum SHALL be DATA_WIDTH wide, cleared in IDLE, and seeded with the LEN byte.
REQ-022 CHECK: on byte_valid, byte_in==checksum -> DRAIN (or frame_done pulse and IDLE when LEN==0); mismatch -> frame_error, IDLE.
REQ-023 DRAIN: payload_valid high, payload_out=buffer[rd_idx]; each cycle with payload_valid&&payload_ready advances rd_idx.
REQ-024 The handshake on the final byte SHALL assert frame_done in the same cycle and return the FSM to IDLE on the next edge.
REQ-025 payload_out SHALL hold stable while payload_valid && !payload_ready.
REQ-026 byte_valid during DRAIN SHALL be dropped; if the dropped byte equals SOF, frame_error SHALL pulse (overrun), and DRAIN continues.
REQ-027 Timeout counter SHALL clear on every byte_valid and in IDLE/DRAIN, and increment on baudTick in LEN/PAYLOAD/CHECK.
REQ-028 When the timeout counter reaches TIMEOUT_TICKS, the block SHALL pulse frame_error and go to IDLE.
REQ-029 byte_valid and the timeout expiring in the same cycle: the byte SHALL win, the counter SHALL clear, and no error SHALL be raised.
REQ-030 frame_done and frame_error SHALL never be asserted in the same cycle.
REQ-031 payload_valid SHALL be low outside DRAIN.
REQ-032 Abort paths SHALL leave buffer contents unchanged but reset wr_idx and rd_idx to 0.

Reset
REQ-033 rstN low SHALL asynchronously force IDLE, with wr_idx, rd_idx, LEN, checksum and timeout counter all 0.
REQ-034 During and after reset, payload_valid=0, frame_done=0, frame_error=0, busy=0 and payload_out=0.
REQ-035 Reset asserted mid-frame or mid-DRAIN SHALL discard the frame without a frame_error pulse.

Configuration
REQ-036 Macro FRAME_CHECKSUM_EN defined: CHK byte expected, CHECK state and XOR logic present.
REQ-037 Macro FRAME_CHECKSUM_EN undefined: no CHECK state and no checksum logic; PAYLOAD goes directly to DRAIN; LEN==0 pulses frame_done from LEN and returns to IDLE.

Verification
REQ-038 With checksum enabled, bytes A5,03,11,22,33,03 and payload_ready=1 -> payload_out 11,22,33 on consecutive cycles; frame_done on the 33 handshake; no frame_error.
REQ-039 Bytes A5,02,10,20,FF (bad CHK) -> frame_error one cycle after FF; payload_valid never asserted; busy=0 afterwards.
REQ-040 Bytes A5,11 (17>MAX_LEN=16) -> frame_error; subsequent A5,01,5A,5B -> payload 5A delivered and frame_done.
REQ-041 Bytes A5,04,01, then 320 baudTicks with no byte -> frame_error on the 320th tick and IDLE; a byte arriving on that same tick is accepted instead, with no error.
REQ-042 Stall payload_ready=0 for 10 cycles in DRAIN -> payload_out held constant; a byte A5 injected during DRAIN -> frame_error pulse, drain completes.
REQ-043 rstN pulsed low in the middle of PAYLOAD -> all outputs 0 immediately; no frame_error; the next valid frame decodes correctly.
